// File: rtl/dco_phase_sampler.sv
// Refclk-domain phase sampler for the ring DCO: Johnson/Gray decode, phase unwrap,
// FCW phase error and windowed frequency measurement.
module dco_phase_sampler #(
  parameter int NUM_STAGES  = 15,
  parameter int CNT_WIDTH   = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int AVG_LOG2    = 4
) (
  input  logic                   refclk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_STAGES-1:0]  ring_state,
  input  logic [CNT_WIDTH-1:0]   cnt_gray,
  input  logic [PHASE_WIDTH-1:0] fcw,
  output logic [PHASE_WIDTH-1:0] dco_phase,
  output logic [PHASE_WIDTH-1:0] dphase,
  output logic [PHASE_WIDTH-1:0] phase_err,
  output logic                   valid,
  output logic [PHASE_WIDTH-1:0] freq_meas,
  output logic                   freq_valid,
  output logic                   bubble_err,
  output logic                   overrange
);

  localparam int FRAC_W = $clog2(2*NUM_STAGES);
  localparam logic [FRAC_W-1:0]      FULL = FRAC_W'(2*NUM_STAGES);
  localparam logic [PHASE_WIDTH-1:0] CYC  = PHASE_WIDTH'(2*NUM_STAGES);

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
  state_t state, state_nxt;

  logic [NUM_STAGES-1:0]  s1_ring;
  logic [CNT_WIDTH-1:0]   s1_cnt;
  logic                   s1_vld;
  logic [FRAC_W-1:0]      s2_frac;
  logic [CNT_WIDTH-1:0]   s2_cnt;
  logic                   s2_bubble;
  logic                   s2_vld;

  logic [FRAC_W-1:0]      pop, frac_dec;
  logic [NUM_STAGES-1:0]  therm, therm_inc;
  logic                   bubble_dec;
  logic [CNT_WIDTH-1:0]   bin_dec;

  logic [CNT_WIDTH-1:0]   cnt_prev, dint;
  logic [FRAC_W-1:0]      frac_prev;
  logic [PHASE_WIDTH-1:0] fcw_acc, step, phase_nxt, acc_nxt, avg_acc, win_sum;
  logic [AVG_LOG2-1:0]    avg_cnt;

  always_ff @(posedge refclk) begin
    if (reset) begin
      s1_ring <= '0;
      s1_cnt  <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= en;
      if (en) begin
        s1_ring <= ring_state;
        s1_cnt  <= cnt_gray;
      end
    end
  end

  // Folding the upper half onto the lower makes every legal code a low-side
  // thermometer, so a single x & (x+1) test catches all bubbles.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      pop = pop + FRAC_W'(s1_ring[i]);
    frac_dec   = s1_ring[NUM_STAGES-1] ? FULL - pop : pop;
    therm      = s1_ring[NUM_STAGES-1] ? ~s1_ring : s1_ring;
    therm_inc  = therm + NUM_STAGES'(1);
    bubble_dec = |(therm & therm_inc);
    bin_dec    = '0;
    for (int unsigned i = 0; i < CNT_WIDTH; i++)
      bin_dec[i] = ^(s1_cnt >> i);
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      s2_frac   <= '0;
      s2_cnt    <= '0;
      s2_bubble <= 1'b0;
      s2_vld    <= 1'b0;
    end else begin
      s2_frac   <= frac_dec;
      s2_cnt    <= bin_dec;
      s2_bubble <= bubble_dec;
      s2_vld    <= s1_vld & en;
    end
  end

  // SEED waits for a sample captured after en rose to reach stage 2.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en && s2_vld) state_nxt = SEED;
      SEED:    state_nxt = en ? RUN : IDLE;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dint      = s2_cnt - cnt_prev;
    step      = CYC * PHASE_WIDTH'(dint) + PHASE_WIDTH'(s2_frac) - PHASE_WIDTH'(frac_prev);
    phase_nxt = dco_phase + step;
    acc_nxt   = fcw_acc + fcw;
    win_sum   = avg_acc + step;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state      <= IDLE;
      cnt_prev   <= '0;
      frac_prev  <= '0;
      fcw_acc    <= '0;
      avg_acc    <= '0;
      avg_cnt    <= '0;
      dco_phase  <= '0;
      dphase     <= '0;
      phase_err  <= '0;
      valid      <= 1'b0;
      freq_meas  <= '0;
      freq_valid <= 1'b0;
      bubble_err <= 1'b0;
      overrange  <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid      <= (state_nxt == RUN);
      freq_valid <= 1'b0;
      bubble_err <= 1'b0;
      overrange  <= 1'b0;
      unique case (state_nxt)
        SEED: begin
          cnt_prev   <= s2_cnt;
          frac_prev  <= s2_frac;
          fcw_acc    <= '0;
          avg_acc    <= '0;
          avg_cnt    <= '0;
          dco_phase  <= '0;
          dphase     <= '0;
          phase_err  <= '0;
          bubble_err <= s2_bubble;
        end
        RUN: begin
          cnt_prev   <= s2_cnt;
          frac_prev  <= s2_frac;
          fcw_acc    <= acc_nxt;
          dco_phase  <= phase_nxt;
          dphase     <= step;
          phase_err  <= acc_nxt - phase_nxt;
          bubble_err <= s2_bubble;
          overrange  <= dint[CNT_WIDTH-1];
          if (&avg_cnt) begin
            freq_meas  <= win_sum;
            freq_valid <= 1'b1;
            avg_acc    <= '0;
            avg_cnt    <= '0;
          end else begin
            avg_acc <= win_sum;
            avg_cnt <= avg_cnt + AVG_LOG2'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dco_phase_sampler.sv
// Randomized self-checking bench for dco_phase_sampler against a sample-level
// phase model (2-edge capture latency, seed on third enabled edge).
module tb_dco_phase_sampler;
  localparam int N    = 15;
  localparam int CW   = 8;
  localparam int PW   = 32;
  localparam int AL   = 4;
  localparam int FULL = 2*N;

  logic          refclk = 1'b0;
  logic          reset, en;
  logic [N-1:0]  ring_state;
  logic [CW-1:0] cnt_gray;
  logic [PW-1:0] fcw;
  logic [PW-1:0] dco_phase, dphase, phase_err, freq_meas;
  logic          valid, freq_valid, bubble_err, overrange;

  always #5 refclk = ~refclk;

  dco_phase_sampler #(
    .NUM_STAGES (N),
    .CNT_WIDTH  (CW),
    .PHASE_WIDTH(PW),
    .AVG_LOG2   (AL)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .en        (en),
    .ring_state(ring_state),
    .cnt_gray  (cnt_gray),
    .fcw       (fcw),
    .dco_phase (dco_phase),
    .dphase    (dphase),
    .phase_err (phase_err),
    .valid     (valid),
    .freq_meas (freq_meas),
    .freq_valid(freq_valid),
    .bubble_err(bubble_err),
    .overrange (overrange)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic logic [N-1:0] legal_code(input int k);
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      c[i] = (k < N) ? (i < k) : (i >= k - N);
    return c;
  endfunction

  function automatic bit is_legal(input logic [N-1:0] r);
    for (int k = 0; k < FULL; k++)
      if (r == legal_code(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int frac_of(input logic [N-1:0] r);
    int p;
    p = $countones(r);
    return r[N-1] ? FULL - p : p;
  endfunction

  function automatic int gray2bin(input int g);
    int b;
    b = 0;
    for (int i = 0; i < CW; i++) b = b ^ (g >> i);
    return b & ((1 << CW) - 1);
  endfunction

  // Reference model state
  int            run_len;
  logic [N-1:0]  h_ring [3];
  int            h_cnt  [3];
  int            m_prev_cnt, m_prev_frac, m_win_n;
  logic [PW-1:0] m_phase, m_acc, m_dph, m_err, m_freq, m_win_sum;
  logic          m_valid, m_fv, m_bub, m_ovr;

  task automatic model_edge();
    int dint, fr;
    h_ring[2] = h_ring[1]; h_ring[1] = h_ring[0]; h_ring[0] = ring_state;
    h_cnt[2]  = h_cnt[1];  h_cnt[1]  = h_cnt[0];  h_cnt[0]  = gray2bin(int'(cnt_gray));
    m_valid = 1'b0; m_fv = 1'b0; m_bub = 1'b0; m_ovr = 1'b0;
    if (reset) begin
      run_len = 0; m_prev_cnt = 0; m_prev_frac = 0; m_win_n = 0;
      m_phase = '0; m_acc = '0; m_dph = '0; m_err = '0; m_freq = '0; m_win_sum = '0;
    end else begin
      run_len = en ? ((run_len < 8) ? run_len + 1 : 8) : 0;
      if (run_len == 3) begin
        m_prev_cnt  = h_cnt[2];
        m_prev_frac = frac_of(h_ring[2]);
        m_phase = '0; m_acc = '0; m_dph = '0; m_err = '0;
        m_win_sum = '0; m_win_n = 0;
        m_bub = !is_legal(h_ring[2]);
      end else if (run_len >= 4) begin
        dint  = (h_cnt[2] - m_prev_cnt) & ((1 << CW) - 1);
        fr    = frac_of(h_ring[2]);
        m_dph = PW'(FULL * dint + fr - m_prev_frac);
        m_phase = m_phase + m_dph;
        m_acc   = m_acc + fcw;
        m_err   = m_acc - m_phase;
        m_valid = 1'b1;
        m_bub   = !is_legal(h_ring[2]);
        m_ovr   = (dint >= (1 << (CW - 1)));
        m_prev_cnt  = h_cnt[2];
        m_prev_frac = fr;
        m_win_sum = m_win_sum + m_dph;
        m_win_n++;
        if (m_win_n == (1 << AL)) begin
          m_freq = m_win_sum; m_fv = 1'b1; m_win_sum = '0; m_win_n = 0;
        end
      end else begin
        m_win_sum = '0; m_win_n = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [N-1:0] ring, input int cbin,
                      input logic [PW-1:0] f);
    int cb;
    cb = cbin & ((1 << CW) - 1);
    reset = r; en = e; ring_state = ring; cnt_gray = CW'(cb ^ (cb >> 1)); fcw = f;
    @(posedge refclk);
    model_edge();
    #1;
    cyc++;
    check("valid",      valid,      m_valid);
    check("dco_phase",  dco_phase,  m_phase);
    check("dphase",     dphase,     m_dph);
    check("phase_err",  phase_err,  m_err);
    check("freq_meas",  freq_meas,  m_freq);
    check("freq_valid", freq_valid, m_fv);
    check("bubble_err", bubble_err, m_bub);
    check("overrange",  overrange,  m_ovr);
  endtask

  task automatic drive_phase(input bit r, input bit e, input longint p, input logic [PW-1:0] f);
    step(r, e, legal_code(int'(p % FULL)), int'((p / FULL) % 256), f);
  endtask

  initial begin
    longint p;
    int     bump;
    p = 0;
    repeat (2) drive_phase(1, 0, p, 32'd3990);

    // Constant frequency, two averaging windows
    repeat (45) begin drive_phase(0, 1, p, 32'd3990); p += 3990; end

    // Mid-run reset then release with en high
    repeat (3) begin drive_phase(1, 1, p, 32'd3990); p += 3990; end
    repeat (8) begin drive_phase(0, 1, p, 32'd3990); p += 3990; end

    // Counter wrap with fraction change, then overrange jumps
    step(0, 1, legal_code(3), 250, 32'd0);
    step(0, 1, legal_code(7),   5, 32'd0);
    step(0, 1, legal_code(7),   5, 32'd0);
    step(0, 1, legal_code(0),   0, 32'd0);
    step(0, 1, legal_code(0),   0, 32'd0);
    step(0, 1, legal_code(0), 200, 32'd0);
    step(0, 1, legal_code(0), 200, 32'd0);

    // Bubble code followed by legal codes
    step(0, 1, 15'b000000000000101, 201, 32'd0);
    repeat (4) step(0, 1, legal_code(2), 201, 32'd0);

    // Tracking with 1-unit/cycle excess, then an en gap and re-seed
    p = 0;
    repeat (20) begin drive_phase(0, 1, p, 32'd3990); p += 3991; end
    repeat (3)  begin drive_phase(0, 0, p, 32'd3990); p += 3991; end
    repeat (12) begin drive_phase(0, 1, p, 32'd3990); p += 3991; end

    // Randomized traffic: gaps, resets, bubbles, large jumps
    repeat (500) begin
      bit r, e;
      logic [N-1:0] ring;
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 15) != 0);
      bump = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30*255)) : int'($urandom_range(0, 30*127));
      p += bump;
      ring = ($urandom_range(0, 15) == 0) ? N'($urandom) : legal_code(int'(p % FULL));
      step(r, e, ring, int'((p / FULL) % 256), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dco_phase_sampler.md
# dco_phase_sampler

Synthesizable refclk-domain phase sampler for the ring DCO. It captures the ring's Johnson-coded stage state and the DCO's Gray-coded integer cycle counter once per refclk, and decodes them into fractional and integer phase. It unwraps the result into a wide accumulated phase, and outputs the per-cycle phase increment, the phase error against an FCW accumulator, and an averaged frequency measurement. It sits between the ring DCO's sampling flops and the digital loop filter.

## Interface
- NUM_STAGES, 15, ring stages (odd, ≥3); one DCO cycle = 2*NUM_STAGES phase units
- CNT_WIDTH, 8, width of the DCO integer cycle counter
- PHASE_WIDTH, 32, width of dco_phase, dphase, phase_err, fcw, freq_meas
- AVG_LOG2, 4, frequency averaging window of 2^AVG_LOG2 valid cycles
- FRAC_W (derived), clog2(2*NUM_STAGES), width of the fractional phase
- refclk  in  1  sampling clock; the only clock
- reset  in  1  synchronous, active-high
- en  in  1  sampling enable
- ring_state  in  NUM_STAGES  sampled ring node levels
- cnt_gray  in  CNT_WIDTH  sampled Gray-coded DCO cycle count
- fcw  in  PHASE_WIDTH  expected phase units per refclk (unsigned)
- dco_phase  out  PHASE_WIDTH  unwrapped phase, wraps modulo 2^PHASE_WIDTH
- dphase  out  PHASE_WIDTH  signed phase increment for the last cycle
- phase_err  out  PHASE_WIDTH  signed fcw_acc − dco_phase
- valid  out  1  dco_phase, dphase and phase_err are meaningful
- freq_meas  out  PHASE_WIDTH  sum of dphase over the averaging window
- freq_valid  out  1  one-cycle strobe when freq_meas updates
- bubble_err  out  1  ring_state was not a legal Johnson code
- overrange  out  1  counter delta ≥ 2^(CNT_WIDTH−1), so aliasing is possible

## Operation
- Fractional decode:
  - p = popcount(ring_state)
  - If ring_state[NUM_STAGES−1] = 0, frac = p; otherwise frac = 2*NUM_STAGES − p.
- Legal codes:
  - Phase k < N: bits [k−1:0] are 1, all others 0.
  - Phase k ≥ N: bits [k−N−1:0] are 0, all others 1.
  - Any other pattern raises bubble_err. Decoding still uses the popcount rule above.
- Integer decode: cnt_bin is cnt_gray converted from Gray to binary.
- Unwrap:
  - dint = (cnt_bin − cnt_prev) mod 2^CNT_WIDTH
  - dphase = 2*NUM_STAGES*dint + frac − frac_prev, computed at PHASE_WIDTH signed width
  - dco_phase += dphase
  - overrange = (dint ≥ 2^(CNT_WIDTH−1)). The computation proceeds unchanged when it is set.
- FCW tracking:
  - fcw_acc += fcw on every valid cycle.
  - phase_err = fcw_acc − dco_phase, computed after both updates and wrapping modulo 2^PHASE_WIDTH.
- Frequency averaging:
  - An accumulator sums dphase over 2^AVG_LOG2 valid cycles.
  - When the window closes, it loads freq_meas, pulses freq_valid for one cycle and restarts from 0.
- FSM states are IDLE, SEED and RUN:
  - reset forces IDLE.
  - IDLE → SEED when en = 1.
  - SEED: the first decoded sample loads cnt_prev and frac_prev, and clears dco_phase, fcw_acc and the averaging accumulator. valid stays 0. Next state is RUN.
  - RUN: unwrap every cycle with valid = 1.
  - RUN → IDLE when en = 0. Outputs hold and valid drops.
  - Re-enabling always passes through SEED. There is no unwrap across a gap.
- Reset values:
  - Every output is 0.
  - fcw_acc, cnt_prev, frac_prev, all pipeline registers and the averaging count are 0.

## Timing
- Pipeline:
  - Stage 1: ring_state and cnt_gray are registered on every refclk edge where en = 1.
  - Stage 2: frac and cnt_bin are registered.
  - Stage 3: unwrap and outputs.
  - A sample captured at edge k drives outputs after edge k+2.
- bubble_err and overrange are aligned with the output of the same sample. They are high for exactly that one cycle.
- Reset release, with reset low first at edge r and en = 1:
  - The edge-r sample is the SEED sample and reaches stage 3 at r+2 with valid = 0.
  - The first valid = 1 appears after edge r+3.
- Asserting reset mid-operation clears everything at the next edge. It overrides en and any pending freq_valid.
- If en falls and the window closes on the same edge, en wins: no freq_valid is issued and the partial window is discarded.
- fcw is sampled in stage 3, on the same edge that updates dco_phase.

## Test plan
- Reset: assert reset for 3 cycles mid-run, then release with en = 1 → all outputs are 0 during reset, valid = 0 for two cycles and first valid = 1 after edge r+3.
- Constant frequency (N = 15): cnt advances by 133 per cycle with ring_state = 0 → dphase = 3990 every cycle and dco_phase = 3990·n.
- Wrap, fraction and overrange:
  - cnt 250 → 5 with frac 3 → 7 gives dint = 11, dphase = 334 and overrange = 0.
  - cnt 0 → 200 gives overrange = 1 for one cycle.
- Bubble: ring_state = 15'b000000000000101 → bubble_err = 1 for one cycle and frac = 2. A legal code on the next cycle clears the flag.
- Averaging (AVG_LOG2 = 4): constant dphase = 3990 → freq_meas = 63840 with a freq_valid pulse every 16 valid cycles.
- Tracking: fcw = 3990 with the DCO advancing 3991 per cycle → phase_err = −1, −2, −3, … Dropping en then re-raising it → SEED, and phase_err restarts at 0.
